// File: rtl/frame_readout_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : frame_readout_sequencer
// Description : Row/column readout sequencer for a gated sensor array. Each
//               row is gated and settled, then every column is converted and
//               the sample is pushed into a FIFO, with back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_readout_sequencer #(
    parameter int GATE_CYC   = 16,
    parameter int SETTLE_CYC = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic        abort,
    input  logic [11:0] n_rows,
    input  logic [11:0] n_cols,
    output logic [11:0] row_addr,
    output logic [11:0] col_addr,
    output logic        gate_pulse,
    output logic        adc_start,
    input  logic        adc_done,
    input  logic [13:0] adc_data,
    output logic        fifo_wr_en,
    output logic [13:0] fifo_wr_data,
    input  logic        fifo_full,
    output logic        frame_busy,
    output logic        frame_complete,
    output logic        cfg_err
);

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] C_GATE_LAST   = CNT_W'(GATE_CYC - 1);
    localparam logic [CNT_W-1:0] C_SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GATE     = 3'd1,
        SETTLE   = 3'd2,
        CONV     = 3'd3,
        WAIT_ADC = 3'd4,
        WRITE    = 3'd5
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [11:0]      r_rows;
    logic [11:0]      r_cols;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_rows         <= '0;
            r_cols         <= '0;
            row_addr       <= '0;
            col_addr       <= '0;
            gate_pulse     <= 1'b0;
            adc_start      <= 1'b0;
            fifo_wr_en     <= 1'b0;
            fifo_wr_data   <= '0;
            frame_busy     <= 1'b0;
            frame_complete <= 1'b0;
            cfg_err        <= 1'b0;
        end else begin
            // Strobe outputs default low; only the transitions below raise them.
            cfg_err        <= 1'b0;
            frame_complete <= 1'b0;
            adc_start      <= 1'b0;
            fifo_wr_en     <= 1'b0;

            if (abort) begin
                r_state    <= IDLE;
                r_cnt      <= '0;
                gate_pulse <= 1'b0;
                frame_busy <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (frame_start) begin
                            if (n_rows != 12'd0 && n_cols != 12'd0) begin
                                r_rows     <= n_rows;
                                r_cols     <= n_cols;
                                row_addr   <= '0;
                                col_addr   <= '0;
                                r_cnt      <= '0;
                                gate_pulse <= 1'b1;
                                frame_busy <= 1'b1;
                                r_state    <= GATE;
                            end else begin
                                cfg_err <= 1'b1;
                            end
                        end
                    end
                    GATE: begin
                        if (r_cnt == C_GATE_LAST) begin
                            r_cnt      <= '0;
                            gate_pulse <= 1'b0;
                            r_state    <= SETTLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    SETTLE: begin
                        if (r_cnt == C_SETTLE_LAST) begin
                            r_cnt     <= '0;
                            adc_start <= 1'b1;
                            r_state   <= CONV;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    CONV: begin
                        r_state <= WAIT_ADC;
                    end
                    WAIT_ADC: begin
                        if (adc_done) begin
                            fifo_wr_data <= adc_data;
                            r_state      <= WRITE;
                        end
                    end
                    WRITE: begin
                        // The write strobe lands in the first cycle of the next
                        // step; fifo_wr_data is untouched until the next adc_done.
                        if (!fifo_full) begin
                            fifo_wr_en <= 1'b1;
                            if (col_addr < r_cols - 12'd1) begin
                                col_addr  <= col_addr + 12'd1;
                                adc_start <= 1'b1;
                                r_state   <= CONV;
                            end else if (row_addr < r_rows - 12'd1) begin
                                col_addr   <= '0;
                                row_addr   <= row_addr + 12'd1;
                                gate_pulse <= 1'b1;
                                r_state    <= GATE;
                            end else begin
                                frame_busy     <= 1'b0;
                                frame_complete <= 1'b1;
                                r_state        <= IDLE;
                            end
                        end
                    end
                    default: begin
                        gate_pulse <= 1'b0;
                        frame_busy <= 1'b0;
                        r_state    <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_readout_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_readout_sequencer
// Description : Scoreboard bench for frame_readout_sequencer with an ADC model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_readout_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        abort = 1'b0;
    logic [11:0] n_rows = '0;
    logic [11:0] n_cols = '0;
    logic [11:0] row_addr;
    logic [11:0] col_addr;
    logic        gate_pulse;
    logic        adc_start;
    logic        adc_done = 1'b0;
    logic [13:0] adc_data = '0;
    logic        fifo_wr_en;
    logic [13:0] fifo_wr_data;
    logic        fifo_full = 1'b0;
    logic        frame_busy;
    logic        frame_complete;
    logic        cfg_err;

    frame_readout_sequencer #(.GATE_CYC(16), .SETTLE_CYC(8)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .abort(abort),
        .n_rows(n_rows), .n_cols(n_cols), .row_addr(row_addr), .col_addr(col_addr),
        .gate_pulse(gate_pulse), .adc_start(adc_start), .adc_done(adc_done),
        .adc_data(adc_data), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
        .fifo_full(fifo_full), .frame_busy(frame_busy),
        .frame_complete(frame_complete), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt = 0, fc_cnt = 0, cfg_cnt = 0, gate_rises = 0, glen = 0;
    bit skip_glen = 1'b0;
    bit adc_en = 1'b1;
    bit spur_req = 1'b0;
    int adc_cnt = 0;
    logic [13:0] adc_lat = '0;
    logic gate_prev = 1'b0;
    logic [13:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [13:0] exp_data(input logic [11:0] r, input logic [11:0] c);
        return {r[6:0], c[6:0]} ^ 14'h2A5;
    endfunction

    // ADC model: answers adc_start with adc_done four cycles later.
    always @(negedge clk) begin
        adc_done = 1'b0;
        if (!rst_n) begin
            adc_cnt = 0;
        end else begin
            if (adc_cnt != 0) begin
                adc_cnt--;
                if (adc_cnt == 0) begin
                    adc_done = 1'b1;
                    adc_data = adc_lat;
                end
            end
            if (adc_start && adc_en) begin
                adc_lat = exp_data(row_addr, col_addr);
                adc_cnt = 4;
            end
        end
        if (spur_req) begin
            adc_done = 1'b1;
            adc_data = 14'h1111;
            spur_req = 1'b0;
        end
    end

    // Output monitor and scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (fifo_wr_en) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    chk("wr_unexpected", 32'(fifo_wr_data), 32'hFFFF);
                end else begin
                    chk("wr_data", 32'(fifo_wr_data), 32'(exp_q.pop_front()));
                end
            end
            if (frame_complete) fc_cnt++;
            if (cfg_err) cfg_cnt++;
            if (gate_pulse && !gate_prev) gate_rises++;
            if (gate_pulse) begin
                glen++;
            end else if (glen != 0) begin
                if (!skip_glen) chk("gate_len", 32'(glen), 32'd16);
                glen = 0;
            end
        end
        gate_prev = gate_pulse;
    end

    task automatic pulse_start(input logic [11:0] r, input logic [11:0] c, input logic ab);
        n_rows = r;
        n_cols = c;
        frame_start = 1'b1;
        abort = ab;
        @(negedge clk);
        frame_start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_fc(input string tag, input int budget);
        int f0 = fc_cnt;
        for (int i = 0; i < budget && fc_cnt == f0; i++) @(negedge clk);
        @(negedge clk);
        chk(tag, 32'(fc_cnt - f0), 32'd1);
    endtask

    task automatic wait_adc_start(input string tag, input int budget);
        int i = 0;
        while (!adc_start && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk(tag, 32'(adc_start), 32'd1);
    endtask

    initial begin
        int w0, g0, c0, f0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(frame_busy), 32'd0);
        chk("rst_gate", 32'(gate_pulse), 32'd0);
        chk("rst_row", 32'(row_addr), 32'd0);
        chk("rst_wdata", 32'(fifo_wr_data), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full 2x3 frame, with a mid-frame start and count change to be ignored.
        w0 = wr_cnt; g0 = gate_rises; c0 = cfg_cnt;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 3; c++) exp_q.push_back(exp_data(12'(r), 12'(c)));
        pulse_start(12'd2, 12'd3, 1'b0);
        chk("start_busy", 32'(frame_busy), 32'd1);
        chk("start_gate", 32'(gate_pulse), 32'd1);
        repeat (30) @(negedge clk);
        pulse_start(12'd5, 12'd0, 1'b0);
        wait_fc("frame1_done", 500);
        chk("frame1_writes", 32'(wr_cnt - w0), 32'd6);
        chk("frame1_gates", 32'(gate_rises - g0), 32'd2);
        chk("frame1_no_cfg_err", 32'(cfg_cnt - c0), 32'd0);
        chk("frame1_q_empty", 32'(exp_q.size()), 32'd0);
        chk("frame1_idle", 32'(frame_busy), 32'd0);
        f0 = fc_cnt;
        repeat (5) @(negedge clk);
        chk("frame1_single_fc", 32'(fc_cnt - f0), 32'd0);

        // FIFO back-pressure while in WRITE.
        w0 = wr_cnt;
        fifo_full = 1'b1;
        exp_q.push_back(exp_data(12'd0, 12'd0));
        pulse_start(12'd1, 12'd1, 1'b0);
        wait_adc_start("stall_adc_start", 100);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("stall_wr_en", 32'(fifo_wr_en), 32'd0);
        end
        chk("stall_held_data", 32'(fifo_wr_data), 32'(exp_data(12'd0, 12'd0)));
        fifo_full = 1'b0;
        wait_fc("stall_done", 100);
        chk("stall_one_write", 32'(wr_cnt - w0), 32'd1);

        // Zero counts are rejected.
        g0 = gate_rises;
        pulse_start(12'd4, 12'd0, 1'b0);
        chk("cfg_err_pulse", 32'(cfg_err), 32'd1);
        chk("cfg_err_busy", 32'(frame_busy), 32'd0);
        @(negedge clk);
        chk("cfg_err_single", 32'(cfg_err), 32'd0);
        pulse_start(12'd0, 12'd4, 1'b0);
        chk("cfg_err_rows0", 32'(cfg_err), 32'd1);
        repeat (20) @(negedge clk);
        chk("cfg_err_no_gate", 32'(gate_rises - g0), 32'd0);
        chk("cfg_err_idle", 32'(frame_busy), 32'd0);

        // Abort during the gate of row 1, then a fresh frame from row 0.
        f0 = fc_cnt;
        exp_q.push_back(exp_data(12'd0, 12'd0));
        pulse_start(12'd2, 12'd1, 1'b0);
        for (int i = 0; i < 200 && !(gate_pulse && row_addr == 12'd1); i++) @(negedge clk);
        chk("abort_row1_gate", 32'(gate_pulse && row_addr == 12'd1), 32'd1);
        repeat (3) @(negedge clk);
        skip_glen = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_gate_low", 32'(gate_pulse), 32'd0);
        chk("abort_busy_low", 32'(frame_busy), 32'd0);
        repeat (40) @(negedge clk);
        skip_glen = 1'b0;
        chk("abort_no_fc", 32'(fc_cnt - f0), 32'd0);
        chk("abort_q_empty", 32'(exp_q.size()), 32'd0);
        exp_q.push_back(exp_data(12'd0, 12'd0));
        pulse_start(12'd1, 12'd1, 1'b0);
        chk("restart_row", 32'(row_addr), 32'd0);
        chk("restart_busy", 32'(frame_busy), 32'd1);
        wait_fc("restart_done", 100);

        // Abort wins over a simultaneous start.
        c0 = cfg_cnt;
        pulse_start(12'd2, 12'd2, 1'b1);
        chk("abort_start_busy", 32'(frame_busy), 32'd0);
        repeat (5) @(negedge clk);
        chk("abort_start_gate", 32'(gate_pulse), 32'd0);
        chk("abort_start_no_cfg", 32'(cfg_cnt - c0), 32'd0);

        // Asynchronous reset while waiting on the ADC.
        adc_en = 1'b0;
        exp_q.push_back(exp_data(12'd0, 12'd0));
        pulse_start(12'd1, 12'd1, 1'b0);
        wait_adc_start("rst_adc_start", 100);
        repeat (2) @(negedge clk);
        chk("rst_pre_busy", 32'(frame_busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_outputs", 32'({row_addr, col_addr, gate_pulse, adc_start, fifo_wr_en,
                                 frame_busy, frame_complete, cfg_err}), 32'd0);
        chk("arst_wdata", 32'(fifo_wr_data), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        adc_en = 1'b1;
        repeat (2) @(negedge clk);

        // Spurious adc_done in IDLE must not write.
        w0 = wr_cnt;
        spur_req = 1'b1;
        repeat (6) @(negedge clk);
        chk("spurious_no_write", 32'(wr_cnt - w0), 32'd0);
        chk("spurious_idle", 32'(frame_busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/frame_readout_sequencer.md
FRAME_READOUT_SEQUENCER -- requirements
Module: frame_readout_sequencer

Interface
REQ-001 SHALL have parameter GATE_CYC, default 16, gate pulse width in clk cycles (>=1).
REQ-002 SHALL have parameter SETTLE_CYC, default 8, post-gate settle time in clk cycles (>=1).
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port frame_start  input  1  single-cycle frame request.
REQ-006 SHALL have port abort  input  1  terminate frame immediately.
REQ-007 SHALL have port n_rows  input  12  row count, sampled at accepted start.
REQ-008 SHALL have port n_cols  input  12  column count, sampled at accepted start.
REQ-009 SHALL have port row_addr  output  12  current row.
REQ-010 SHALL have port col_addr  output  12  current column.
REQ-011 SHALL have port gate_pulse  output  1  row gate drive.
REQ-012 SHALL have port adc_start  output  1  single-cycle conversion request.
REQ-013 SHALL have port adc_done  input  1  conversion-complete strobe.
REQ-014 SHALL have port adc_data  input  14  sample; valid when adc_done is high.
REQ-015 SHALL have port fifo_wr_en  output  1  FIFO write strobe.
REQ-016 SHALL have port fifo_wr_data  output  14  FIFO write data.
REQ-017 SHALL have port fifo_full  input  1  FIFO cannot accept data.
REQ-018 SHALL have port frame_busy  output  1  high in any non-IDLE state.
REQ-019 SHALL have port frame_complete  output  1  single-cycle end-of-frame pulse.
REQ-020 SHALL have port cfg_err  output  1  single-cycle pulse on rejected start.

Function
REQ-021 SHALL implement the states IDLE, GATE, SETTLE, CONV, WAIT_ADC, WRITE.
REQ-022 SHALL accept frame_start only in IDLE with n_rows!=0 and n_cols!=0, then latch both counts, set row_addr=0 and col_addr=0, and enter GATE on the next cycle.
REQ-023 SHALL, on frame_start in IDLE with either count 0, pulse cfg_err for 1 cycle the next cycle and remain in IDLE.
REQ-024 SHALL ignore frame_start when not in IDLE, with no cfg_err.
REQ-025 SHALL hold gate_pulse high for exactly GATE_CYC cycles in GATE, then enter SETTLE for exactly SETTLE_CYC cycles, then enter CONV.
REQ-026 SHALL, in CONV, assert adc_start for exactly 1 cycle with col_addr valid, then enter WAIT_ADC.
REQ-027 SHALL honour adc_done only in WAIT_ADC; on adc_done it SHALL capture adc_data into fifo_wr_data and enter WRITE.
REQ-028 SHALL, in WRITE with fifo_full low, assert fifo_wr_en for 1 cycle; with fifo_full high, hold fifo_wr_en low and stall with data held until fifo_full is low, with no loss and no duplication.
REQ-029 SHALL, after the write, increment col and enter CONV when col<n_cols-1; otherwise set col=0, increment row and enter GATE when row<n_rows-1; otherwise pulse frame_complete for 1 cycle and enter IDLE.
REQ-030 SHALL hold row_addr and col_addr stable between updates and never exceed the latched count minus 1.
REQ-031 SHALL, on abort in any state, enter IDLE on the next cycle and deassert gate_pulse, adc_start, fifo_wr_en and frame_busy, with no frame_complete.
REQ-032 SHALL, when abort and frame_start occur in the same cycle, give priority to abort and not start a frame.
REQ-033 SHALL ignore changes to n_rows and n_cols during a frame.

Reset
REQ-034 SHALL, while rst_n is low, force IDLE and drive all outputs to 0 (row_addr=0, col_addr=0, fifo_wr_data=0), including when reset is asserted mid-frame.

Verification
REQ-035 SHALL verify that start with n_rows=2, n_cols=3 and adc_done 4 cycles after each adc_start gives gate_pulse high exactly 16 cycles, twice; 6 fifo_wr_en pulses in order (r0c0..r1c2); and a single frame_complete.
REQ-036 SHALL verify that holding fifo_full high 10 cycles in WRITE gives fifo_wr_en low throughout, then exactly 1 write of the held sample once fifo_full falls.
REQ-037 SHALL verify that start with n_cols=0 gives a cfg_err pulse, frame_busy staying 0 and no gate_pulse.
REQ-038 SHALL verify that abort during GATE of row 1 gives gate_pulse low and IDLE next cycle, no frame_complete, and that a fresh start then restarts at row 0.
REQ-039 SHALL verify that a second frame_start during a frame is ignored, and that abort+frame_start in the same cycle in IDLE leaves frame_busy 0.
REQ-040 SHALL verify that rst_n low during WAIT_ADC gives all outputs 0 asynchronously, and that a spurious adc_done in IDLE gives no write.
